mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-port arbiter between instruction-fetch and data clients and the cpu side of the RAM interface.
- Grants one client at a time and forwards its request on memREN/memWEN/memaddr/memstore.
- Holds the client's wait line until ramstate reports ACCESS or ERROR, then returns ramload.
- Sits directly upstream of the RAM, driving the ram_if cpu modport.

Parameters:
- WORD_W, 32, data/address width; equals word_t width.
- TIMEOUT, 64, max cycles in a grant state without ACCESS/ERROR before abort; must be ≥2.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request, level; held until iwait=0.
- iaddr  in  WORD_W  instruction address.
- iwait  out  1  instruction client stall.
- iload  out  WORD_W  instruction read data.
- dREN  in  1  data read request, level.
- dWEN  in  1  data write request, level; dREN&dWEN together is illegal.
- daddr  in  WORD_W  data address.
- dstore  in  WORD_W  data write value.
- dwait  out  1  data client stall.
- dload  out  WORD_W  data read data.
- ramstate  in  ramstate_t  RAM status (FREE, BUSY, ACCESS, ERROR).
- ramload  in  WORD_W  RAM read data.
- memREN  out  1  forwarded read enable.
- memWEN  out  1  forwarded write enable.
- memaddr  out  WORD_W  forwarded address.
- memstore  out  WORD_W  forwarded write data.
- merr  out  1  one-cycle pulse on ERROR or timeout.

Behaviour:
- FSM states (arb_state_t): IDLE, IGNT, DGNT. Reset → IDLE, last_d=0, timer=0.
- Reset values: all outputs 0, except iwait=1 and dwait=1 whenever the respective request is high.
- IDLE:
  - No mem* asserted.
  - If exactly one client requests, go to its grant state next edge.
  - If both request, round-robin: grant data if last_d=0, otherwise instruction.
  - Update last_d on every grant.
- IGNT/DGNT:
  - mem* driven combinationally from the granted client (memREN=iREN in IGNT; memREN=dREN, memWEN=dWEN, memstore=dstore in DGNT).
  - Ungranted client's wait stays 1.
- Completion: ramstate==ACCESS in a grant state →
  - granted wait=0 that same cycle;
  - load output = ramload (combinational);
  - FSM → IDLE next edge.
  - Minimum per-access latency is 2 cycles (grant edge + ACCESS cycle).
- ERROR in a grant state → wait=0, merr=1 for that cycle, load=0, → IDLE.
- Timer:
  - Counts cycles in a grant state; clears in IDLE.
  - At timer==TIMEOUT-1 without ACCESS/ERROR: wait=0, merr=1, load=0, → IDLE.
- Request drop: granted client deasserts its request mid-grant → mem* drop immediately, → IDLE next edge, no merr.
- Simultaneous ACCESS and request drop: the drop wins; nothing is delivered.
- Loads outside a completion cycle are 0.
- Reset asserted mid-grant: immediate return to IDLE, mem* = 0, timer cleared.
- Back-to-back: a client re-requesting in the cycle after completion re-arbitrates from IDLE, giving one bubble cycle.

Optional Feature:
- Macro: MEM_ARBITER_PERF_EN.
- When defined, adds outputs icount, dcount, stallcount (32 bits each, saturating, reset 0):
  - icount: increments on each instruction completion;
  - dcount: increments on each data completion;
  - stallcount: increments on every cycle any wait=1.
- When undefined, these ports and their registers do not exist; functionality is otherwise identical.

Decomposition:
- ram_pkg additions: arb_state_t (2-bit enum IDLE=0, IGNT=1, DGNT=2).
- ramstate_t and word_t are reused from ram_pkg unchanged.
- One sub-module, mem_arb_timer: clear/enable inputs, expire output, counter width $clog2(TIMEOUT).

Test Plan:
- Reset with iREN=1 → iwait=1, memREN=0; release, iaddr=0x100, ramstate=ACCESS on 3rd cycle, ramload=0xDEADBEEF → iload=0xDEADBEEF, iwait=0 that cycle only.
- Both clients request continuously, ACCESS every other cycle → grants alternate D,I,D,I; last_d toggles each grant.
- dWEN=1, daddr=0x40, dstore=0x1234, ramstate=BUSY 5 cycles then ACCESS → memWEN=1, memaddr=0x40, memstore=0x1234 held 6 cycles; dwait falls on ACCESS.
- ramstate stuck BUSY, TIMEOUT=8 → dwait falls at cycle 8 of grant with merr=1 one cycle; FSM back to IDLE.
- ramstate=ERROR during IGNT → iwait=0, merr=1, iload=0; nRST pulsed mid-DGNT → memREN/memWEN=0 asynchronously, state IDLE.

Source files
------------

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared RAM interface types: word, RAM status and arbiter state encodings.
package ram_pkg;

  localparam int RAM_WORD_W = 32;

  typedef logic [RAM_WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - grant watchdog; o_expire is high on the TIMEOUT-th enabled cycle.
module mem_arb_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of instruction/data clients onto the RAM cpu port.
// Optional MEM_ARBITER_PERF_EN adds saturating completion and stall counters.
module mem_arbiter
  import ram_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  input  ramstate_t         ramstate,
  input  logic [WORD_W-1:0] ramload,
  output logic              memREN,
  output logic              memWEN,
  output logic [WORD_W-1:0] memaddr,
  output logic [WORD_W-1:0] memstore,
  output logic              merr
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [31:0]       icount,
  output logic [31:0]       dcount,
  output logic [31:0]       stallcount
`endif
);

  arb_state_t r_state, w_next;
  logic       r_last_d, w_next_last_d;
  logic       w_dreq, w_igrant, w_dgrant;
  logic       w_access, w_error, w_expire;

  assign w_dreq   = dREN | dWEN;
  assign w_igrant = (r_state == IGNT) && iREN;
  assign w_dgrant = (r_state == DGNT) && w_dreq;
  assign w_access = (ramstate == ACCESS);
  assign w_error  = (ramstate == ERROR);

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk    (CLK),
    .i_rst_n  (nRST),
    .i_clear  (r_state == IDLE),
    .i_enable (r_state != IDLE),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_last_d <= w_next_last_d;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_next_last_d = r_last_d;
    case (r_state)
      IDLE: begin
        // On contention the client not served last time wins.
        if (iREN && w_dreq) begin
          w_next        = r_last_d ? IGNT : DGNT;
          w_next_last_d = !r_last_d;
        end else if (iREN) begin
          w_next        = IGNT;
          w_next_last_d = 1'b0;
        end else if (w_dreq) begin
          w_next        = DGNT;
          w_next_last_d = 1'b1;
        end
      end
      IGNT:    if (!iREN || w_access || w_error || w_expire) w_next = IDLE;
      DGNT:    if (!w_dreq || w_access || w_error || w_expire) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    iwait    = iREN;
    dwait    = w_dreq;
    iload    = '0;
    dload    = '0;
    memREN   = 1'b0;
    memWEN   = 1'b0;
    memaddr  = '0;
    memstore = '0;
    merr     = 1'b0;
    case (r_state)
      IGNT: if (w_igrant) begin
        memREN  = 1'b1;
        memaddr = iaddr;
        if (w_access) begin
          iwait = 1'b0;
          iload = ramload;
        end else if (w_error || w_expire) begin
          iwait = 1'b0;
          merr  = 1'b1;
        end
      end
      DGNT: if (w_dgrant) begin
        memREN   = dREN;
        memWEN   = dWEN;
        memaddr  = daddr;
        memstore = dstore;
        if (w_access) begin
          dwait = 1'b0;
          dload = ramload;
        end else if (w_error || w_expire) begin
          dwait = 1'b0;
          merr  = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] r_icount, r_dcount, r_stallcount;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_icount     <= '0;
      r_dcount     <= '0;
      r_stallcount <= '0;
    end else begin
      if (w_igrant && w_access && (r_icount != '1)) r_icount <= r_icount + 32'd1;
      if (w_dgrant && w_access && (r_dcount != '1)) r_dcount <= r_dcount + 32'd1;
      if ((iwait || dwait) && (r_stallcount != '1)) r_stallcount <= r_stallcount + 32'd1;
    end
  end

  assign icount     = r_icount;
  assign dcount     = r_dcount;
  assign stallcount = r_stallcount;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (TIMEOUT=8).
module tb_mem_arbiter;
  import ram_pkg::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         iREN, dREN, dWEN;
  logic [W-1:0] iaddr, daddr, dstore, ramload;
  ramstate_t    ramstate;
  logic         iwait, dwait, memREN, memWEN, merr;
  logic [W-1:0] iload, dload, memaddr, memstore;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.WORD_W(W), .TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramstate(ramstate), .ramload(ramload),
    .memREN(memREN), .memWEN(memWEN), .memaddr(memaddr), .memstore(memstore),
    .merr(merr)
  );

  always #5 CLK = ~CLK;

  task automatic drive_idle();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    nRST = 0; iREN = 1; iaddr = 32'h100;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL reset_iwait got %0h want 1", iwait); end
    checks++; if (memREN !== 1'b0) begin errors++; $display("FAIL reset_memren got %0h want 0", memREN); end
    checks++; if (dwait !== 1'b0 || merr !== 1'b0 || iload !== '0) begin errors++; $display("FAIL reset_outs got dwait=%0h merr=%0h iload=%0h want 0", dwait, merr, iload); end
    @(negedge CLK); nRST = 1;
    @(negedge CLK); ramstate = BUSY; #1;
    checks++; if (memREN !== 1'b1 || memaddr !== 32'h100 || iwait !== 1'b1) begin errors++; $display("FAIL ifetch_c1 got ren=%0h addr=%0h iwait=%0h want 1 100 1", memREN, memaddr, iwait); end
    @(negedge CLK); #1;
    checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL ifetch_c2 got iwait=%0h want 1", iwait); end
    @(negedge CLK); ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    checks++; if (iwait !== 1'b0 || iload !== 32'hDEADBEEF) begin errors++; $display("FAIL ifetch_access got iwait=%0h iload=%0h want 0 deadbeef", iwait, iload); end
    @(negedge CLK); ramstate = FREE; #1;
    checks++; if (iwait !== 1'b1 || iload !== '0 || memREN !== 1'b0) begin errors++; $display("FAIL ifetch_after got iwait=%0h iload=%0h ren=%0h want 1 0 0", iwait, iload, memREN); end
    #1 iREN = 0;
  endtask

  task automatic test_round_robin();
    logic         exp_d;
    logic [W-1:0] exp_addr;
    @(negedge CLK);
    iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h300; ramstate = FREE; #1;
    checks++; if (memREN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL rr_idle got ren=%0h iw=%0h dw=%0h want 0 1 1", memREN, iwait, dwait); end
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      exp_addr = exp_d ? 32'h300 : 32'h200;
      @(negedge CLK); ramstate = ACCESS; ramload = 32'hA000 + k; #1;
      checks++; if (memaddr !== exp_addr || iwait !== exp_d || dwait !== !exp_d) begin errors++; $display("FAIL rr_grant%0d got addr=%0h iw=%0h dw=%0h want %0h %0h %0h", k, memaddr, iwait, dwait, exp_addr, exp_d, !exp_d); end
      checks++; if ((exp_d ? dload : iload) !== 32'hA000 + k) begin errors++; $display("FAIL rr_load%0d got i=%0h d=%0h want %0h", k, iload, dload, 32'hA000 + k); end
      @(negedge CLK); ramstate = FREE; #1;
      checks++; if (memREN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL rr_bubble%0d got ren=%0h iw=%0h dw=%0h want 0 1 1", k, memREN, iwait, dwait); end
    end
    #1 iREN = 0; dREN = 0;
  endtask

  task automatic test_write_busy();
    @(negedge CLK);
    dWEN = 1; daddr = 32'h40; dstore = 32'h1234; ramstate = BUSY; #1;
    checks++; if (memWEN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL wr_idle got wen=%0h dw=%0h want 0 1", memWEN, dwait); end
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (c == 5) begin ramstate = ACCESS; ramload = 32'h55; end
      #1;
      checks++; if (memWEN !== 1'b1 || memREN !== 1'b0 || memaddr !== 32'h40 || memstore !== 32'h1234) begin errors++; $display("FAIL wr_fwd%0d got wen=%0h ren=%0h addr=%0h st=%0h want 1 0 40 1234", c, memWEN, memREN, memaddr, memstore); end
      checks++; if (dwait !== (c < 5)) begin errors++; $display("FAIL wr_dwait%0d got %0h want %0h", c, dwait, (c < 5)); end
    end
    checks++; if (dload !== 32'h55) begin errors++; $display("FAIL wr_dload got %0h want 55", dload); end
    @(negedge CLK); dWEN = 0; ramstate = FREE; #1;
    checks++; if (memWEN !== 1'b0 || dload !== '0) begin errors++; $display("FAIL wr_after got wen=%0h dload=%0h want 0 0", memWEN, dload); end
  endtask

  task automatic test_timeout();
    @(negedge CLK);
    dREN = 1; daddr = 32'h80; ramstate = BUSY; ramload = 32'h77;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK); #1;
      checks++; if (dwait !== (c < 8) || merr !== (c == 8) || memREN !== 1'b1) begin errors++; $display("FAIL to_c%0d got dw=%0h merr=%0h ren=%0h want %0h %0h 1", c, dwait, merr, memREN, (c < 8), (c == 8)); end
    end
    checks++; if (dload !== '0) begin errors++; $display("FAIL to_dload got %0h want 0", dload); end
    @(negedge CLK); #1;
    checks++; if (memREN !== 1'b0 || merr !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL to_idle got ren=%0h merr=%0h dw=%0h want 0 0 1", memREN, merr, dwait); end
    #1 dREN = 0;
  endtask

  task automatic test_error_and_reset();
    @(negedge CLK);
    iREN = 1; iaddr = 32'h10; ramstate = FREE;
    @(negedge CLK); ramstate = ERROR; ramload = 32'hFFFF; #1;
    checks++; if (iwait !== 1'b0 || merr !== 1'b1 || iload !== '0 || memREN !== 1'b1) begin errors++; $display("FAIL err_cycle got iw=%0h merr=%0h iload=%0h ren=%0h want 0 1 0 1", iwait, merr, iload, memREN); end
    @(negedge CLK); iREN = 0; ramstate = FREE; #1;
    checks++; if (merr !== 1'b0 || memREN !== 1'b0) begin errors++; $display("FAIL err_after got merr=%0h ren=%0h want 0 0", merr, memREN); end
    @(negedge CLK); dWEN = 1; daddr = 32'h44; ramstate = BUSY;
    @(negedge CLK); #1;
    checks++; if (memWEN !== 1'b1) begin errors++; $display("FAIL rst_pre got wen=%0h want 1", memWEN); end
    #1 nRST = 0; #1;
    checks++; if (memWEN !== 1'b0 || memREN !== 1'b0 || memaddr !== '0 || dwait !== 1'b1) begin errors++; $display("FAIL rst_async got wen=%0h ren=%0h addr=%0h dw=%0h want 0 0 0 1", memWEN, memREN, memaddr, dwait); end
    @(negedge CLK); nRST = 1; #1;
    checks++; if (memWEN !== 1'b0) begin errors++; $display("FAIL rst_idle got wen=%0h want 0", memWEN); end
    @(negedge CLK); #1;
    checks++; if (memWEN !== 1'b1 || memaddr !== 32'h44) begin errors++; $display("FAIL rst_regrant got wen=%0h addr=%0h want 1 44", memWEN, memaddr); end
    #1 dWEN = 0; ramstate = FREE;
  endtask

  task automatic test_drop();
    @(negedge CLK);
    iREN = 1; iaddr = 32'h20; ramstate = BUSY;
    @(negedge CLK); #1;
    checks++; if (memREN !== 1'b1 || memaddr !== 32'h20) begin errors++; $display("FAIL drop_grant got ren=%0h addr=%0h want 1 20", memREN, memaddr); end
    @(negedge CLK); iREN = 0; ramstate = ACCESS; ramload = 32'hAA; #1;
    checks++; if (memREN !== 1'b0 || memaddr !== '0 || iload !== '0 || merr !== 1'b0 || iwait !== 1'b0) begin errors++; $display("FAIL drop_cycle got ren=%0h addr=%0h iload=%0h merr=%0h iw=%0h want 0 0 0 0 0", memREN, memaddr, iload, merr, iwait); end
    @(negedge CLK); dREN = 1; daddr = 32'h30; ramstate = FREE; #1;
    checks++; if (memREN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL drop_idle got ren=%0h dw=%0h want 0 1", memREN, dwait); end
    @(negedge CLK); #1;
    checks++; if (memREN !== 1'b1 || memaddr !== 32'h30) begin errors++; $display("FAIL drop_next got ren=%0h addr=%0h want 1 30", memREN, memaddr); end
    #1 dREN = 0;
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_busy();
    test_timeout();
    test_error_and_reset();
    test_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
